// File: rtl/uart_pkg.sv
// Shared UART definitions for the oversampling receiver and the future transmitter.
// Contents:
//   uart_state_e       - frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   SAMPLE_OFS_*       - positions of the three mid-bit sample ticks, relative to OVERSAMPLE/2
//   PARITY_EVEN/ODD    - parity sense constants
//   majority3()        - 2-of-3 vote used to decide each bit
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int SAMPLE_OFS_EARLY = -1;
    localparam int SAMPLE_OFS_MID   = 0;
    localparam int SAMPLE_OFS_LATE  = 1;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side word interface of the oversampling UART receiver.
//   rx_data    - received word (DATA_BITS wide), stable while rx_valid
//   rx_valid   - word available, held until rx_valid & rx_ready on a clock edge
//   rx_ready   - consumer accepts the word
//   frame_err  - qualifies rx_data: a stop bit was sampled 0
//   parity_err - qualifies rx_data: parity mismatch
//   overrun    - one-cycle pulse: a frame was dropped because the word was not taken
//   busy       - receiver is inside a frame
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a one-clock tick_o pulse every CLK_DIV clocks.
// restart_i clears the divider so the first tick lands exactly CLK_DIV clocks
// after the restart, aligning the tick grid to the start edge of a frame.
// Ports: clk, rst_n (async, active low), restart_i, tick_o (registered).
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    // Divider counter and registered tick, high while cnt_q sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            tick_q <= (cnt_q == CNT_PRE);
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver.
// Synchronizes the asynchronous rx line, times each bit with OVERSAMPLE ticks of
// uart_baud_tick, decides each bit by 2-of-3 majority around mid-bit, rejects
// start glitches, flags framing errors, detects overrun and (optionally) checks parity.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
// Ports:
//   clk, rst_n - single clock, asynchronous active-low reset
//   rx         - serial line, idle high, asynchronous to clk
//   rx_if      - uart_rx_os_if.master: word, valid/ready handshake, error flags, busy
module uart_rx_os #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    uart_rx_os_if.master rx_if
);
    import uart_pkg::*;

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] T_EARLY = TICK_W'(OVERSAMPLE / 2 + SAMPLE_OFS_EARLY);
    localparam logic [TICK_W-1:0] T_MID   = TICK_W'(OVERSAMPLE / 2 + SAMPLE_OFS_MID);
    localparam logic [TICK_W-1:0] T_LATE  = TICK_W'(OVERSAMPLE / 2 + SAMPLE_OFS_LATE);
    localparam logic [TICK_W-1:0] T_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic                 tick_s, restart_s, decide_s, bit_s, perr_s, stop_err_s;
    uart_state_e          state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [1:0]           vote_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 ferr_q, brk_q, done_q, busy_q;
    logic [DATA_BITS-1:0] frame_data_q;
    logic                 frame_ferr_q, frame_perr_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q;

`ifdef UART_RX_PARITY_EN
    logic                 perr_q;
    assign perr_s = perr_q;
`else
    // PARITY_ODD only matters when the parity bit exists.
    logic                 unused_parity_cfg_s;
    assign unused_parity_cfg_s = PARITY_ODD;
    assign perr_s = 1'b0;
`endif

    // Two-flop synchronizer plus a history flop for falling-edge detection; idle-high preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign restart_s  = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;
    // The third sample is taken directly from rxs_q in the decision cycle.
    assign decide_s   = tick_s && (tick_cnt_q == T_LATE);
    assign bit_s      = majority3(vote_q[0], vote_q[1], rxs_q);
    assign stop_err_s = ferr_q | ~bit_s;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart_s),
        .tick_o    (tick_s)
    );

    // Frame FSM with tick/bit counters, mid-bit voting and the completed-frame capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            vote_q       <= 2'b00;
            shift_q      <= '0;
            ferr_q       <= 1'b0;
            brk_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_data_q <= '0;
            frame_ferr_q <= 1'b0;
            frame_perr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // Tick position within the current bit; held at 0 between frames.
            if (state_q == ST_IDLE) begin
                tick_cnt_q <= '0;
            end else if (tick_s) begin
                tick_cnt_q <= (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
            end
            if (tick_s && (tick_cnt_q == T_EARLY)) begin
                vote_q[0] <= rxs_q;
            end
            if (tick_s && (tick_cnt_q == T_MID)) begin
                vote_q[1] <= rxs_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (restart_s) begin
                        state_q   <= ST_START;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        ferr_q    <= 1'b0;
                        brk_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide_s) begin
                        if (bit_s) begin
                            // Line was high at mid-bit: a glitch, not a start bit.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide_s) begin
                        shift_q <= {bit_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (decide_s) begin
                        perr_q  <= bit_s ^ (^shift_q) ^ PARITY_ODD;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (brk_q) begin
                        // Break in progress: hold off until the line returns high.
                        if (rxs_q) begin
                            brk_q   <= 1'b0;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (decide_s) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            done_q       <= 1'b1;
                            frame_data_q <= shift_q;
                            frame_ferr_q <= stop_err_s;
                            frame_perr_q <= perr_s;
                            if (stop_err_s && !rxs_q) begin
                                brk_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            ferr_q    <= stop_err_s;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output word register: load a completed frame, flag overrun, or clear on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                // A load wins over a same-cycle handshake so back-to-back words survive.
                if (!rx_valid_q || rx_if.rx_ready) begin
                    rx_data_q    <= frame_data_q;
                    frame_err_q  <= frame_ferr_q;
                    parity_err_q <= frame_perr_q;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.overrun    = overrun_q;
    assign rx_if.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: two instances (8N1 and 9-bit/2-stop) fed by
// bit-level waveforms built from frame contents; a handshake monitor collects words
// and the expected words/flags come from the frame contents themselves.
module tb_uart_rx_os;
    localparam int C    = 4;
    localparam int OS   = 16;
    localparam int BITC = C * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    word_t got_a[$];
    word_t got_b[$];
    int   ovr_a = 0, ovr_b = 0, vcyc_a = 0;

    always #5 clk = ~clk;

    uart_rx_os_if #(.DATA_BITS(8)) ifa ();
    uart_rx_os_if #(.DATA_BITS(9)) ifb ();

    uart_rx_os #(.CLK_DIV(C), .OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0))
        dut_a (.clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_if(ifa));
    uart_rx_os #(.CLK_DIV(C), .OVERSAMPLE(OS), .DATA_BITS(9), .STOP_BITS(2), .PARITY_ODD(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_if(ifb));

    // Monitor on the falling edge: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.rx_valid && ifa.rx_ready)
                got_a.push_back('{data: {1'b0, ifa.rx_data}, fe: ifa.frame_err, pe: ifa.parity_err});
            if (ifb.rx_valid && ifb.rx_ready)
                got_b.push_back('{data: ifb.rx_data, fe: ifb.frame_err, pe: ifb.parity_err});
            if (ifa.overrun) ovr_a++;
            if (ifb.overrun) ovr_b++;
            if (ifa.rx_valid) vcyc_a++;
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bit period; spike_at >= 0 inverts the line for one tick starting at that tick.
    task automatic drive_bit(input bit sel, input logic v, input int spike_at);
        for (int c = 0; c < BITC; c++) begin
            logic w;
            w = v;
            if (spike_at >= 0 && c >= spike_at * C && c < (spike_at + 1) * C) w = ~v;
            if (sel) rx_b = w;
            else     rx_a = w;
            step();
        end
    endtask

    task automatic idle_bits(input bit sel, input int n);
        for (int i = 0; i < n; i++) drive_bit(sel, 1'b1, -1);
    endtask

    // Complete frame; the parity bit (when built in) is correct unless par_flip is set.
    task automatic send_frame(input bit sel, input int data, input int nbits, input int nstop,
                              input logic stop_v, input logic par_flip, input bit noisy);
        logic p;
        p = 1'b0;
        drive_bit(sel, 1'b0, noisy ? int'($urandom_range(8, 10)) : -1);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = 1'((data >> i) & 1);
            p = p ^ b;
            drive_bit(sel, b, noisy ? int'($urandom_range(8, 10)) : -1);
        end
        if (PAR_EN) drive_bit(sel, p ^ par_flip, -1);
        for (int s = 0; s < nstop; s++)
            drive_bit(sel, stop_v, noisy ? int'($urandom_range(8, 9)) : -1);
    endtask

    function automatic word_t word_a(input int i);
        if (i < got_a.size()) return got_a[i];
        return '{data: 9'h1FF, fe: 1'bx, pe: 1'bx};
    endfunction

    function automatic word_t word_b(input int i);
        if (i < got_b.size()) return got_b[i];
        return '{data: 9'h000, fe: 1'bx, pe: 1'bx};
    endfunction

    task automatic chk_a(input string tag, input int i, input int d, input logic fe, input logic pe);
        word_t w;
        w = word_a(i);
        chk({tag, ".data"}, 32'(w.data), 32'(d));
        chk({tag, ".fe"}, 32'(w.fe), 32'(fe));
        chk({tag, ".pe"}, 32'(w.pe), 32'(pe));
    endtask

    initial begin
        int base, ov0, vc0;
        int expq[$];
        ifa.rx_ready = 1'b1;
        ifb.rx_ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst.valid", 32'(ifa.rx_valid), 32'd0);
        chk("rst.data", 32'(ifa.rx_data), 32'd0);
        chk("rst.busy", 32'(ifa.busy), 32'd0);
        chk("rst.ferr", 32'(ifa.frame_err), 32'd0);
        chk("rst.ovr", 32'(ifa.overrun), 32'd0);
        chk("rst.perr", 32'(ifa.parity_err), 32'd0);
        rst_n = 1'b1;
        idle_bits(1'b0, 1);

        // 1: frame 0x55, word valid for exactly one clock
        vc0 = vcyc_a;
        send_frame(1'b0, 8'h55, 8, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(1'b0, 1);
        chk("t1.count", 32'(got_a.size()), 32'd1);
        chk_a("t1", 0, 8'h55, 1'b0, 1'b0);
        chk("t1.validcycles", 32'(vcyc_a - vc0), 32'd1);

        // 2: 6-tick low glitch is rejected before the next bit period
        base = got_a.size();
        rx_a = 1'b0;
        repeat (12) step();
        chk("t2.busy_during", 32'(ifa.busy), 32'd1);
        repeat (6 * C - 12) step();
        rx_a = 1'b1;
        repeat (60 - 6 * C) step();
        chk("t2.busy_after", 32'(ifa.busy), 32'd0);
        idle_bits(1'b0, 2);
        chk("t2.count", 32'(got_a.size()), 32'(base));

        // 3: framing error, then a 20-bit break reported once
        base = got_a.size();
        send_frame(1'b0, 8'hA3, 8, 1, 1'b0, 1'b0, 1'b0);
        idle_bits(1'b0, 2);
        chk("t3.count", 32'(got_a.size()), 32'(base + 1));
        chk_a("t3", base, 8'hA3, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive_bit(1'b0, 1'b0, -1);
        chk("t3.brk_busy", 32'(ifa.busy), 32'd1);
        chk("t3.brk_count", 32'(got_a.size()), 32'(base + 2));
        chk_a("t3.brk", base + 1, 8'h00, 1'b1, 1'b0);
        rx_a = 1'b1;
        repeat (8) step();
        chk("t3.idle_after", 32'(ifa.busy), 32'd0);
        idle_bits(1'b0, 2);
        chk("t3.no_retrigger", 32'(got_a.size()), 32'(base + 2));

        // 4: overrun keeps the first word; consuming it drops rx_valid
        base = got_a.size();
        ov0 = ovr_a;
        ifa.rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, 8, 1, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 8'h22, 8, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(1'b0, 1);
        chk("t4.overruns", 32'(ovr_a - ov0), 32'd1);
        chk("t4.valid", 32'(ifa.rx_valid), 32'd1);
        chk("t4.data_kept", 32'(ifa.rx_data), 32'h11);
        ifa.rx_ready = 1'b1;
        step();
        step();
        chk("t4.valid_dropped", 32'(ifa.rx_valid), 32'd0);
        chk("t4.count", 32'(got_a.size()), 32'(base + 1));
        chk_a("t4", base, 8'h11, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        // 5: parity 0x07, wrong then right parity bit
        base = got_a.size();
        send_frame(1'b0, 8'h07, 8, 1, 1'b1, 1'b1, 1'b0);
        send_frame(1'b0, 8'h07, 8, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(1'b0, 1);
        chk_a("t5.bad", base, 8'h07, 1'b0, 1'b1);
        chk_a("t5.good", base + 1, 8'h07, 1'b0, 1'b0);
`endif

        // Random words, random gaps, random mid-bit noise, against the frame-content model
        base = got_a.size();
        ov0 = ovr_a;
        for (int k = 0; k < 6; k++) begin
            int d;
            d = int'($urandom_range(0, 255));
            expq.push_back(d);
            send_frame(1'b0, d, 8, 1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            idle_bits(1'b0, int'($urandom_range(0, 2)));
        end
        idle_bits(1'b0, 1);
        chk("rnd.count", 32'(got_a.size() - base), 32'(expq.size()));
        for (int k = 0; k < expq.size(); k++) chk_a("rnd", base + k, expq[k], 1'b0, 1'b0);
        chk("rnd.overruns", 32'(ovr_a - ov0), 32'd0);

        // 6: reset mid-frame clears a pending word and aborts the frame
        ifa.rx_ready = 1'b0;
        send_frame(1'b0, 8'h5A, 8, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(1'b0, 1);
        chk("t6.pending", 32'(ifa.rx_data), 32'h5A);
        drive_bit(1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'((8'h3C >> i) & 1), -1);
        rx_a = 1'b1;
        repeat (8 * C) step();
        chk("t6.busy_before", 32'(ifa.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6.valid", 32'(ifa.rx_valid), 32'd0);
        chk("t6.data", 32'(ifa.rx_data), 32'd0);
        chk("t6.busy", 32'(ifa.busy), 32'd0);
        chk("t6.ferr", 32'(ifa.frame_err), 32'd0);
        chk("t6.ovr", 32'(ifa.overrun), 32'd0);
        repeat (5) step();
        rst_n = 1'b1;
        ifa.rx_ready = 1'b1;
        idle_bits(1'b0, 1);
        base = got_a.size();
        send_frame(1'b0, 8'h3C, 8, 1, 1'b1, 1'b0, 1'b0);
        idle_bits(1'b0, 1);
        chk("t6.count", 32'(got_a.size()), 32'(base + 1));
        chk_a("t6.after", base, 8'h3C, 1'b0, 1'b0);

        // 7: ten back-to-back noisy 0x1FF frames, 9 data bits, 2 stop bits
        ov0 = ovr_b;
        for (int k = 0; k < 10; k++) send_frame(1'b1, 9'h1FF, 9, 2, 1'b1, 1'b0, 1'b1);
        idle_bits(1'b1, 1);
        chk("t7.count", 32'(got_b.size()), 32'd10);
        chk("t7.overruns", 32'(ovr_b - ov0), 32'd0);
        for (int k = 0; k < 10; k++) begin
            word_t w;
            w = word_b(k);
            chk("t7.data", 32'(w.data), 32'h1FF);
            chk("t7.fe", 32'(w.fe), 32'd0);
            chk("t7.pe", 32'(w.pe), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
